// File: rtl/result_lane_serializer_if.sv
// rtl/result_lane_serializer_if.sv - stream bundle around the result lane serializer
// slave: the serializer's own view; master: the core/DMA neighbours driving it.
interface result_lane_serializer_if #(
  parameter int DATAOUT_WIDTH = 57,
  parameter int BUS_WIDTH     = 32
);
  logic [DATAOUT_WIDTH-1:0] s_axis_tdata;
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [BUS_WIDTH-1:0]     m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/result_lane_serializer.sv
// rtl/result_lane_serializer.sv - splits packed core results into one lane per output beat
// Optional clamp of each lane to SAT_WIDTH unsigned: define RESULT_SAT_EN.
module result_lane_serializer #(
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int BUS_WIDTH    = 32,
  parameter int FRAME_WORDS  = 3,
  parameter int SAT_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  result_lane_serializer_if.slave       bus,
  output logic                          frame_done
);

  localparam int SUM_WIDTH     = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE;
  localparam int DATAOUT_WIDTH = SUM_WIDTH * KERNEL_SIZE;
  localparam int LANE_W        = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int WORD_W        = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  generate
    if (BUS_WIDTH < SUM_WIDTH) begin : g_bad_bus
      $error("BUS_WIDTH must be >= SUM_WIDTH");
    end
    if (FRAME_WORDS < 1) begin : g_bad_frame
      $error("FRAME_WORDS must be >= 1");
    end
    if (SAT_WIDTH < 1) begin : g_bad_sat
      $error("SAT_WIDTH must be >= 1");
    end
  endgenerate

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [DATAOUT_WIDTH-1:0] hold;
  logic [LANE_W-1:0]        lane;
  logic [WORD_W-1:0]        word;
  logic                     full;
  logic                     last_lane;
  logic                     last_word;
  logic                     s_ready;
  logic                     in_fire;
  logic                     out_fire;
  logic [SUM_WIDTH-1:0]     lane_val;
  logic [SUM_WIDTH-1:0]     lane_out;

  assign full      = (state == HOLD);
  assign last_lane = (lane == LANE_W'(KERNEL_SIZE - 1));
  assign last_word = (word == WORD_W'(FRAME_WORDS - 1));
  // Draining the last lane frees the holding register in the same edge, so the
  // next word can be taken without a bubble.
  assign s_ready   = !full || (bus.m_axis_tready && last_lane);
  assign in_fire   = bus.s_axis_tvalid && s_ready;
  assign out_fire  = full && bus.m_axis_tready;

  // State register: EMPTY while nothing is held, HOLD while a word is being serialized.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= EMPTY;
    else       state <= state_next;
  end

  // Next state: leave HOLD only when the last lane goes out and no new word arrives.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (in_fire) state_next = HOLD;
      HOLD:    if (out_fire && last_lane) state_next = in_fire ? HOLD : EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Holding register, lane/word counters and the registered end-of-frame pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold       <= '0;
      lane       <= '0;
      word       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_fire && last_lane && last_word;
      if (in_fire) hold <= bus.s_axis_tdata;
      if (out_fire) begin
        if (last_lane) begin
          lane <= '0;
          word <= last_word ? '0 : word + WORD_W'(1);
        end else begin
          lane <= lane + LANE_W'(1);
        end
      end
    end
  end

  // Lane select: lane 0 sits in the most significant field.
  always_comb begin
    lane_val = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      if (lane == LANE_W'(i)) lane_val = hold[DATAOUT_WIDTH-1-i*SUM_WIDTH -: SUM_WIDTH];
    end
  end

`ifdef RESULT_SAT_EN
  localparam logic [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'((64'd1 << SAT_WIDTH) - 64'd1);

  // Clamp: any bit set at or above SAT_WIDTH means the value overflows the cell.
  always_comb begin
    lane_out = lane_val;
    if (|(lane_val >> SAT_WIDTH)) lane_out = SAT_MAX;
  end
`else
  // Pass the full sum through unchanged.
  always_comb begin
    lane_out = lane_val;
  end
`endif

  // Outputs: data is forced to zero while empty so idle beats carry no stale lanes.
  always_comb begin
    bus.s_axis_tready = s_ready;
    bus.m_axis_tvalid = full;
    bus.m_axis_tlast  = full && last_lane && last_word;
    bus.m_axis_tdata  = full ? BUS_WIDTH'(lane_out) : '0;
  end

endmodule

// File: doc/result_lane_serializer.md
Name: result_lane_serializer

Overview:
- Downstream neighbour of the convolution/matrix core (`top`). Consumes its m_axis result word: KERNEL_SIZE packed partial sums, each SUM_WIDTH bits wide.
- Emits one lane per beat on a BUS_WIDTH AXI-stream toward the DMA/inflation-map writer, zero-extended.
- Marks the end of each result frame with tlast.
- Holds exactly one input word, so the core's output never has to stall for more than the serialization time.

Parameters:
- KERNEL_SIZE, 3, lanes per input word.
- DATA_WIDTH, 8, core data width; used only to derive SUM_WIDTH.
- WEIGHT_WIDTH, 8, core weight width; used only to derive SUM_WIDTH.
- BUS_WIDTH, 32, output bus width. Must be >= SUM_WIDTH; elaboration fails otherwise.
- FRAME_WORDS, 3, input words per frame (rows of the result matrix). Must be >= 1.
- SAT_WIDTH, 8, saturation width. Used only with RESULT_SAT_EN.
- Derived: SUM_WIDTH = DATA_WIDTH+WEIGHT_WIDTH+KERNEL_SIZE (19); DATAOUT_WIDTH = SUM_WIDTH*KERNEL_SIZE (57).

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATAOUT_WIDTH  packed lanes; lane 0 = [DATAOUT_WIDTH-1 -: SUM_WIDTH], lane i = next field down.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  block can accept a word.
- m_axis_tdata  out  BUS_WIDTH  one lane, unsigned, zero-extended.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream accepts beat.
- m_axis_tlast  out  1  last beat of a frame.
- frame_done  out  1  one-cycle pulse when a tlast beat completes.

Behaviour:
- Storage: one DATAOUT_WIDTH holding register, flag full, lane counter lane (0..KERNEL_SIZE-1), word counter word (0..FRAME_WORDS-1).
- Reset (async assert, sync release): full=0, lane=0, word=0, holding register=0, frame_done=0. Outputs then read m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=1.
- Reset mid-operation: held word and partial frame are discarded; the next accepted word starts frame word 0.
- State machine:
  - EMPTY (full=0): s_axis_tready=1. On s_axis_tvalid, capture the word, lane=0, go to HOLD.
  - HOLD (full=1): m_axis_tvalid=1; m_axis_tdata = lane[lane] (processed as below).
  - Each output handshake (m_axis_tvalid && m_axis_tready) increments lane.
  - At lane==KERNEL_SIZE-1 the handshake instead sets lane=0 and advances word (wraps to 0 after FRAME_WORDS-1).
  - It then returns to EMPTY, unless a new input word is accepted in the same cycle; in that case it captures it and stays in HOLD.
- s_axis_tready = !full || (m_axis_tready && lane==KERNEL_SIZE-1). This combinational path from m_axis_tready gives back-to-back words with no bubble.
- Latency: word accepted at edge N -> lane 0 valid from cycle N+1.
- Throughput: one beat per cycle while m_axis_tready=1; KERNEL_SIZE cycles per word.
- m_axis_tlast = full && lane==KERNEL_SIZE-1 && word==FRAME_WORDS-1.
- frame_done is registered: asserts the cycle after the tlast handshake, for one cycle.
- AXI rule: while m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tlast hold stable.
- m_axis_tvalid never drops without a handshake, except on reset.
- Input words offered while full and not draining the last lane are not accepted (tready=0); no loss.
- Arithmetic: lanes are unsigned. Bits above SUM_WIDTH (or above SAT_WIDTH with saturation) are 0.
- KERNEL_SIZE=1: every handshake is a last-lane handshake.
- FRAME_WORDS=1: tlast is asserted on every word's last lane.

Optional Feature:
- Macro: RESULT_SAT_EN.
- Defined: each lane is clamped to SAT_WIDTH unsigned. Values > 2^SAT_WIDTH-1 output 2^SAT_WIDTH-1; values are then zero-extended to BUS_WIDTH. Intended for 8-bit inflation-map cells.
- Undefined: full SUM_WIDTH value is zero-extended; SAT_WIDTH is ignored.
- Handshake and timing are identical in both builds.

Test Plan:
- Reset, then one word {19'd84,19'd90,19'd96}, m_axis_tready=1 -> beats 0x54, 0x5A, 0x60 on consecutive cycles starting 1 cycle after acceptance; tlast=0; s_axis_tready low for the first 2 beats.
- Three words rows {84,90,96}, {201,216,231}, {318,342,366} held valid back-to-back, tready=1 -> 9 beats, no idle cycles. tlast only on beat 9 (0x16E, unsaturated). frame_done pulses once, one cycle after beat 9.
- Backpressure: m_axis_tready toggled 1,0,0,1,... during row 2 -> each beat is held stable while stalled; no beat is duplicated or dropped; order is 201, 216, 231.
- RESULT_SAT_EN defined, row {318,342,366} -> 0xFF, 0xFF, 0xFF. Row {84,90,96} -> 0x54, 0x5A, 0x60. Undefined build gives 0x13E, 0x156, 0x16E for the first row.
- Assert rstn=0 after 4 beats of a frame, release, resend 3 words -> tvalid=0 during reset; the new frame's tlast falls on its own 9th beat.
- Idle input with tready=1 -> m_axis_tvalid stays 0 and s_axis_tready stays 1 indefinitely.
